filtd_unit: RTL and testbench



---
 rtl/filtd_unit.sv | 111 +++++++++++
 tb/tb_filtd_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/filtd_unit.sv
// -----------------------------------------------------------------------------
// filtd_unit
//
// G.726 ADPCM FILTD block: low-pass filter for the fast quantizer scale factor.
// It computes the unlimited fast scale factor
//
//     YUT = Y + ((WI - Y) >> 5)
//
// with the ITU integer arithmetic (17-bit difference, arithmetic shift by 5,
// 13-bit modulo sum) and registers the result.
//
// It sits between the log-scale multiplier (WI) and the scale-factor limiter
// (LIMB) in both the encoder and the decoder.
//
// Ports:
//   clk        in   1   system clock, rising-edge active
//   reset_n    in   1   asynchronous active-low reset
//   in_valid   in   1   WI/Y sample valid this cycle
//   WI         in  12   scale-factor multiplier, 2's complement
//   Y          in  13   quantizer scale factor, unsigned
//   out_valid  out  1   YUT updated this cycle
//   YUT        out 13   unlimited fast scale factor, unsigned
//
// Handshake: a sample is taken on every rising clk edge where in_valid=1.
// Exactly one cycle later out_valid=1 and YUT carries its result. There is no
// ready signal; the consumer must take every out_valid pulse. While
// in_valid=0 the WI/Y inputs are ignored and YUT holds its last value.
//
// Build option:
//   FILTD_LIMB_EN  when defined, the registered YUT is clamped to the LIMB
//                  range [544, 5120] after the modulo-8192 sum. When
//                  undefined, YUT is the raw filter output and matches the
//                  ITU reference vectors bit-exactly.
//
// Reset value of YUT is 0 in both builds.
// -----------------------------------------------------------------------------
module filtd_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [11:0] WI,
    input  logic [12:0] Y,
    output logic        out_valid,
    output logic [12:0] YUT
);

    // Smallest and largest scale factor accepted by LIMB.
    localparam logic [12:0] LIMB_LO = 13'd544;
    localparam logic [12:0] LIMB_HI = 13'd5120;

    logic [16:0] dif;
    logic        difs;
    logic [12:0] difsx;
    logic [12:0] yut_c;
    logic [12:0] yut_next;

    // The ITU form adds 131072 before subtracting Y so the difference stays
    // non-negative; modulo 2^17 that constant is zero, so the plain 17-bit
    // subtraction gives exactly the same bits.
    always_comb begin
        dif = {WI, 5'b00000} - {4'b0000, Y};
    end

    // dif >> 5 is dif[16:5]; its top bit is already the sign, so
    // "zero-extend then add 4096 when negative" is the same as copying the
    // sign into bit 12.
    always_comb begin
        difs  = dif[16];
        difsx = {difs, dif[16:5]};
    end

    // Modulo-8192 sum: wrap-around is intended, not saturation.
    always_comb begin
        yut_c = Y + difsx;
    end

`ifdef FILTD_LIMB_EN
    // Clamp the already-wrapped sum into the LIMB range.
    always_comb begin
        yut_next = yut_c;
        if (yut_c < LIMB_LO) begin
            yut_next = LIMB_LO;
        end else if (yut_c > LIMB_HI) begin
            yut_next = LIMB_HI;
        end
    end
`else
    // Raw filter output; the limit constants exist only for the clamped build.
    logic unused_limb;
    always_comb begin
        unused_limb = ^{LIMB_LO, LIMB_HI};
        yut_next    = yut_c;
    end
`endif

    // Output register. out_valid is a one-cycle pulse per accepted sample;
    // YUT only moves on accepted samples so idle (possibly undefined) inputs
    // never reach it. An asynchronous reset discards any sample in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            YUT       <= 13'd0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                YUT <= yut_next;
            end
        end
    end

endmodule

// File: tb/tb_filtd_unit.sv
// -----------------------------------------------------------------------------
// tb_filtd_unit
//
// Self-checking bench for filtd_unit. A behavioural model computes
// YUT = Y + floor((WI - Y) / 32) using plain signed integer arithmetic,
// folding the 17-bit wrap of the difference and the modulo-8192 sum.
// A compare process checks out_valid and YUT one time unit after every
// rising edge. Directed vectors pin the model with literal results.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_filtd_unit;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [11:0] WI;
    logic [12:0] Y;
    logic        out_valid;
    logic [12:0] YUT;

    int checks;
    int errors;

    // Scoreboard state
    logic [12:0] exp_q[$];
    logic [12:0] model_hold;
    logic        exp_vld;

    filtd_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .WI        (WI),
        .Y         (Y),
        .out_valid (out_valid),
        .YUT       (YUT)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic [12:0] model_yut(input logic [11:0] wi, input logic [12:0] y);
        int wi_s;
        int y_i;
        int d;
        int r;
        logic [12:0] res;
        wi_s = int'($signed(wi));
        y_i  = int'(y);
        d    = wi_s * 32 - y_i;
        // Difference lives in 17 bits (two's complement)
        d = ((d % 131072) + 131072) % 131072;
        if (d >= 65536) d = d - 131072;
        r = y_i + (d >>> 5);
        r = ((r % 8192) + 8192) % 8192;
`ifdef FILTD_LIMB_EN
        if (r < 544)  r = 544;
        if (r > 5120) r = 5120;
`endif
        res = r[12:0];
        return res;
    endfunction

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Asynchronous reset flushes the model immediately.
    always @(negedge reset_n) begin
        exp_q.delete();
        model_hold = 13'd0;
    end

    // Model sampling and per-cycle compare.
    always @(posedge clk) begin
        logic smp_v;
        logic [11:0] smp_wi;
        logic [12:0] smp_y;
        smp_v  = in_valid;
        smp_wi = WI;
        smp_y  = Y;
        exp_vld = 1'b0;
        if (reset_n === 1'b1 && smp_v === 1'b1) begin
            exp_q.push_back(model_yut(smp_wi, smp_y));
            exp_vld = 1'b1;
        end
        #1;
        check("out_valid", {12'd0, out_valid}, {12'd0, exp_vld});
        if (exp_vld) begin
            if (exp_q.size() > 0) model_hold = exp_q.pop_front();
        end
        check("yut_model", YUT, model_hold);
    end

    // ---------------- driver tasks ----------------
    task automatic drive_sample(input logic [11:0] wi, input logic [12:0] y);
        @(negedge clk);
        in_valid = 1'b1;
        WI       = wi;
        Y        = y;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        in_valid = 1'b0;
        WI       = 12'bx;
        Y        = 13'bx;
    endtask

    // Drive one sample and check the literal result after the next edge.
    task automatic directed(input string name, input logic [11:0] wi, input logic [12:0] y,
                            input logic [12:0] exp);
        drive_sample(wi, y);
        @(posedge clk);
        #2;
        check({name, "_valid"}, {12'd0, out_valid}, 13'd1);
        check(name, YUT, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks   = 0;
        errors   = 0;
        model_hold = 13'd0;
        exp_vld  = 1'b0;
        reset_n  = 1'b0;
        in_valid = 1'b1;
        WI       = 12'($urandom);
        Y        = 13'($urandom);

        // Reset held with valid random inputs: outputs stay cleared.
        repeat (3) begin
            @(negedge clk);
            WI = 12'($urandom);
            Y  = 13'($urandom);
        end
        check("reset_yut", YUT, 13'd0);
        check("reset_valid", {12'd0, out_valid}, 13'd0);

        // Release mid-cycle (between negedge and posedge); first update at next edge.
        in_valid = 1'b0;
        #2 reset_n = 1'b1;
        #1;
        check("release_yut", YUT, 13'd0);

        // Basic vector, then idle: hold.
        directed("basic", 12'h400, 13'd544, 13'd1551);
        drive_idle();
        @(posedge clk);
        #2;
        check("hold_valid", {12'd0, out_valid}, 13'd0);
        check("hold_yut", YUT, 13'h60F);
        drive_idle();

        // Back-to-back directed vectors, one result per cycle in order.
`ifdef FILTD_LIMB_EN
        directed("neg_zero", 12'h000, 13'd544,  13'd544);
        directed("neg_fff",  12'hFFF, 13'd544,  13'd544);
`else
        directed("neg_zero", 12'h000, 13'd544,  13'd527);
        directed("neg_fff",  12'hFFF, 13'd544,  13'd526);
`endif
        directed("upper",    12'h000, 13'd5120, 13'd4960);
        directed("wrap",     12'h7FF, 13'd8191, 13'd1790);
        directed("basic_b2b", 12'h400, 13'd544, 13'd1551);
        drive_idle();

        // Randomized stream with random idle gaps (undefined idle inputs).
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                logic [11:0] rw;
                logic [12:0] ry;
                rw = 12'($urandom);
                ry = 13'($urandom);
                // Bias some samples toward the interesting edges.
                case ($urandom_range(0, 7))
                    0: ry = 13'h1FFF;
                    1: ry = 13'd0;
                    2: rw = 12'h800;
                    3: rw = 12'h7FF;
                    default: ;
                endcase
                drive_sample(rw, ry);
            end else begin
                drive_idle();
            end
        end

        // Mid-stream reset: sample in flight is discarded.
        drive_sample(12'h123, 13'd1000);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_yut", YUT, 13'd0);
        check("midreset_valid", {12'd0, out_valid}, 13'd0);
        @(posedge clk);
        #2;
        check("midreset_edge_valid", {12'd0, out_valid}, 13'd0);
        @(negedge clk);
        reset_n = 1'b1;
        directed("post_reset", 12'h400, 13'd544, 13'd1551);
        drive_idle();
        repeat (3) @(posedge clk);
        #3;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
